// File: rtl/uart_responder_if.sv
// CPU-facing strobe/flag handshake of the UART responder. The tristate data bus
// stays a plain inout on the responder so it resolves like a board-level net.
`timescale 1ns/1ps
interface uart_responder_if;
  // rdn/wrn are active-low strobes; a read or write commits on the strobe's
  // rising edge. data_ready/tbre/tsre/overrun are level flags sampled at will.
  logic rdn;
  logic wrn;
  logic data_ready;
  logic tbre;
  logic tsre;
  logic overrun;

  modport master (output rdn, wrn, input data_ready, tbre, tsre, overrun);
  modport slave  (input rdn, wrn, output data_ready, tbre, tsre, overrun);
endinterface

// File: rtl/uart_responder.sv
// Peripheral end of the rdn/wrn UART handshake: byte-wide THR/RBR on the shared
// bus, 8N1 serializer on txd, deserializer on rxd.
`timescale 1ns/1ps
module uart_responder #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic            clk,
  input  logic            rst,
  uart_responder_if.slave bus,
  inout  wire [15:0]      data_io,
  output logic            txd,
  input  logic            rxd,
  output logic [1:0]      tx_state_dbg,
  output logic [1:0]      rx_state_dbg
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Strobes are synchronized as active-high "asserted" levels, so a commit is
  // the 1->0 transition of the synchronized level.
  logic rd_s1, rd_s2, rd_d, wr_s1, wr_s2, wr_d, rx_s1, rx_s2;
  logic rd_commit, wr_commit;

  logic [7:0] wr_hold, thr, tsr, rbr, rx_shift;
  logic thr_empty, tsr_empty, rbr_full, rbr_overrun, rx_ferr;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_idx, rx_idx;
  tx_state_e tx_state, tx_next;
  rx_state_e rx_state, rx_next;
  logic tx_load, tx_done, rx_sample, rx_commit, rx_ferr_set;
  logic unused_bus_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      {rd_s1, rd_s2, rd_d, wr_s1, wr_s2, wr_d} <= '0;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rd_s1 <= ~bus.rdn;
      rd_s2 <= rd_s1;
      rd_d  <= rd_s2;
      wr_s1 <= ~bus.wrn;
      wr_s2 <= wr_s1;
      wr_d  <= wr_s2;
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  // Overlapping read and write strobes: the read owns the bus and the write is lost.
  assign rd_commit = ~rd_s2 & rd_d;
  assign wr_commit = ~wr_s2 & wr_d & ~rd_s2 & ~rd_d;

  assign data_io       = rd_s2 ? {8'h00, rbr} : 16'hzzzz;
  assign unused_bus_hi = ^data_io[15:8];

  always_ff @(posedge clk) begin
    if (rst)
      wr_hold <= '0;
    else if (!bus.wrn)
      wr_hold <= data_io[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_done = 1'b0;
    txd     = 1'b1;
    case (tx_state)
      TX_IDLE: if (!thr_empty) begin
        tx_load = 1'b1;
        tx_next = TX_START;
      end
      TX_START: begin
        txd = 1'b0;
        if (tx_cnt == CNT_LAST) tx_next = TX_DATA;
      end
      TX_DATA: begin
        txd = tsr[tx_idx];
        if (tx_cnt == CNT_LAST && tx_idx == 3'd7) tx_next = TX_STOP;
      end
      TX_STOP: if (tx_cnt == CNT_LAST) begin
        // A byte already waiting in THR follows the stop bit with no idle gap.
        if (!thr_empty) begin
          tx_load = 1'b1;
          tx_next = TX_START;
        end else begin
          tx_done = 1'b1;
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr       <= '0;
      tsr       <= '0;
      thr_empty <= 1'b1;
      tsr_empty <= 1'b1;
      tx_cnt    <= '0;
      tx_idx    <= '0;
    end else begin
      if (wr_commit && thr_empty) begin
        thr       <= wr_hold;
        thr_empty <= 1'b0;
      end
      if (tx_load) begin
        tsr       <= thr;
        thr_empty <= 1'b1;
        tsr_empty <= 1'b0;
      end
      if (tx_done) tsr_empty <= 1'b1;
      tx_cnt <= (tx_next != tx_state || tx_cnt == CNT_LAST || tx_state == TX_IDLE)
                ? '0 : tx_cnt + CNT_W'(1);
      if (tx_state != TX_DATA)   tx_idx <= '0;
      else if (tx_cnt == CNT_LAST) tx_idx <= tx_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    rx_sample   = 1'b0;
    rx_commit   = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == CNT_LAST) begin
        rx_sample = 1'b1;
        if (rx_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: begin
        // After a framing error, hold here until the line returns to mark.
        if (rx_ferr) begin
          if (rx_s2) rx_next = RX_IDLE;
        end else if (rx_cnt == CNT_LAST) begin
          if (rx_s2) begin
            rx_commit = 1'b1;
            rx_next   = RX_IDLE;
          end else begin
            rx_ferr_set = 1'b1;
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbr         <= '0;
      rx_shift    <= '0;
      rbr_full    <= 1'b0;
      rbr_overrun <= 1'b0;
      rx_ferr     <= 1'b0;
      rx_cnt      <= '0;
      rx_idx      <= '0;
    end else begin
      if (rx_sample) rx_shift <= {rx_s2, rx_shift[7:1]};
      if (rx_commit) begin
        rbr         <= rx_shift;
        rbr_full    <= 1'b1;
        rbr_overrun <= rd_commit ? 1'b0 : rbr_full;
      end else if (rd_commit) begin
        rbr_full    <= 1'b0;
        rbr_overrun <= 1'b0;
      end
      rx_ferr <= rx_ferr_set | (rx_ferr & (rx_next == RX_STOP));
      rx_cnt  <= (rx_next != rx_state || rx_cnt == CNT_LAST || rx_state == RX_IDLE)
                 ? '0 : rx_cnt + CNT_W'(1);
      if (rx_state != RX_DATA)     rx_idx <= '0;
      else if (rx_cnt == CNT_LAST) rx_idx <= rx_idx + 3'd1;
    end
  end

  assign bus.data_ready = rbr_full;
  assign bus.overrun    = rbr_overrun;
  assign bus.tbre       = thr_empty;
  assign bus.tsre       = tsr_empty;
  assign tx_state_dbg   = tx_state;
  assign rx_state_dbg   = rx_state;
endmodule
